conv_controller: RTL and testbench

CONV_CONTROLLER -- requirements
Module: conv_controller

---
 rtl/conv_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_conv_controller.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_controller.sv
`default_nettype none
// ============================================================================
// Module   : conv_controller
// Purpose  : Sequencing FSM for a 3x3 convolution engine. It loads the weight
//            header, then for each image reads the row/column dimensions,
//            fills three input rows, and alternates CONV -> FLUSH -> WRITE
//            until the last input row has been consumed. A 16'h00FF word in
//            place of the row count ends the job.
// Ports    : clk, reset (sync, active-high)
//            dut_run            - start request, sampled only in IDLE
//            sram_dut_read_data - input SRAM word at the current read address
//            last_col_next      - next column increment reaches last column
//            last_row_flag      - last input row is loaded
//            18 single-bit strobes/levels to the datapath (all registered)
//            state              - current state encoding (debug/coverage)
// Revision : 1.0 - initial release
// ============================================================================
module conv_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        dut_run,
  input  logic [15:0] sram_dut_read_data,
  input  logic        last_col_next,
  input  logic        last_row_flag,
  output logic        dut_busy_toggle,
  output logic        str_weights_dims,
  output logic        str_weights_data,
  output logic        rst_dut_wmem_read_address,
  output logic        str_input_nrows,
  output logic        str_input_ncols,
  output logic        incr_raddr_enable,
  output logic        pln_input_row_enable,
  output logic        incr_row_enable,
  output logic        rst_row_counter,
  output logic        incr_col_enable,
  output logic        rst_col_counter,
  output logic        update_d_in,
  output logic        toggle_conv_go_flag,
  output logic        dut_sram_write_enable,
  output logic        incr_waddr_enable,
  output logic        incr_output_addr,
  output logic        rst_output_row_temp,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    W_DIM   = 4'd1,
    W_DAT   = 4'd2,
    RD_WAIT = 4'd3,
    I_NROW  = 4'd4,
    I_NCOL  = 4'd5,
    FILL    = 4'd6,
    CONV    = 4'd7,
    FLUSH   = 4'd8,
    WRITE   = 4'd9,
    DONE    = 4'd10
  } state_t;

  typedef struct packed {
    logic busy_toggle;
    logic weights_dims;
    logic weights_data;
    logic rst_raddr;
    logic input_nrows;
    logic input_ncols;
    logic incr_raddr;
    logic pln_row;
    logic incr_row;
    logic rst_row;
    logic incr_col;
    logic rst_col;
    logic upd_d_in;
    logic toggle_go;
    logic wr_en;
    logic incr_waddr;
    logic incr_oaddr;
    logic rst_orow;
  } strobe_t;

  localparam logic [15:0] END_MARKER = 16'h00FF;

  state_t     state_q, state_d;
  state_t     ret_q, ret_d;        // state RD_WAIT hands control back to
  logic [1:0] fill_cnt_q, fill_cnt_d;
  logic       phase_q, phase_d;    // second cycle of W_DAT / FLUSH / WRITE
  strobe_t    strb_q, strb_d;

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    fill_cnt_d = fill_cnt_q;
    phase_d    = 1'b0;
    strb_d     = '0;

    case (state_q)
      IDLE: begin
        strb_d.rst_col = 1'b1;
        strb_d.rst_row = 1'b1;
        if (dut_run) begin
          strb_d.busy_toggle = 1'b1;
          state_d            = W_DIM;
        end
      end
      W_DIM: begin
        strb_d.weights_dims = 1'b1;
        state_d             = W_DAT;
      end
      W_DAT: begin
        // First cycle only waits for the word at address 1 to arrive.
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          strb_d.weights_data = 1'b1;
          state_d             = RD_WAIT;
          ret_d               = I_NROW;
        end
      end
      RD_WAIT: begin
        state_d = ret_q;
      end
      I_NROW: begin
        if (sram_dut_read_data == END_MARKER) begin
          state_d = DONE;
        end else begin
          strb_d.input_nrows = 1'b1;
          strb_d.incr_raddr  = 1'b1;
          state_d            = RD_WAIT;
          ret_d              = I_NCOL;
        end
      end
      I_NCOL: begin
        strb_d.input_ncols = 1'b1;
        strb_d.incr_raddr  = 1'b1;
        fill_cnt_d         = 2'd0;
        state_d            = RD_WAIT;
        ret_d              = FILL;
      end
      FILL: begin
        strb_d.pln_row    = 1'b1;
        strb_d.incr_raddr = 1'b1;
        strb_d.incr_row   = 1'b1;
        fill_cnt_d        = fill_cnt_q + 2'd1;
        // Decision uses the post-increment count: three rows fill the window.
        if (fill_cnt_d == 2'd3) begin
          strb_d.rst_col = 1'b1;
          state_d        = CONV;
        end else begin
          state_d = RD_WAIT;
          ret_d   = FILL;
        end
      end
      CONV: begin
        strb_d.upd_d_in = 1'b1;
        strb_d.incr_col = 1'b1;
        if (last_col_next) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Two cycles to drain the two-stage adder pipeline.
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (!phase_q) begin
          strb_d.wr_en      = 1'b1;
          strb_d.incr_waddr = 1'b1;
          strb_d.incr_oaddr = 1'b1;
          phase_d           = 1'b1;
        end else begin
          strb_d.rst_orow = 1'b1;
          strb_d.rst_col  = 1'b1;
          state_d         = RD_WAIT;
          if (last_row_flag) begin
            ret_d = I_NROW;
          end else begin
            strb_d.pln_row    = 1'b1;
            strb_d.incr_raddr = 1'b1;
            strb_d.incr_row   = 1'b1;
            ret_d             = CONV;
          end
        end
      end
      DONE: begin
        strb_d.busy_toggle = 1'b1;
        state_d            = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // conv_go flips on every CONV entry and every CONV exit, so it always
    // ends an image back at 0.
    strb_d.toggle_go = ((state_d == CONV) && (state_q != CONV)) ||
                       ((state_q == CONV) && last_col_next);
    // Level output: tracks the state being entered so it lines up with state.
    strb_d.rst_raddr = (state_d != IDLE) && (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ret_q      <= IDLE;
      fill_cnt_q <= 2'd0;
      phase_q    <= 1'b0;
      strb_q     <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      fill_cnt_q <= fill_cnt_d;
      phase_q    <= phase_d;
      strb_q     <= strb_d;
    end
  end

  assign state                     = state_q;
  assign dut_busy_toggle           = strb_q.busy_toggle;
  assign str_weights_dims          = strb_q.weights_dims;
  assign str_weights_data          = strb_q.weights_data;
  assign rst_dut_wmem_read_address = strb_q.rst_raddr;
  assign str_input_nrows           = strb_q.input_nrows;
  assign str_input_ncols           = strb_q.input_ncols;
  assign incr_raddr_enable         = strb_q.incr_raddr;
  assign pln_input_row_enable      = strb_q.pln_row;
  assign incr_row_enable           = strb_q.incr_row;
  assign rst_row_counter           = strb_q.rst_row;
  assign incr_col_enable           = strb_q.incr_col;
  assign rst_col_counter           = strb_q.rst_col;
  assign update_d_in               = strb_q.upd_d_in;
  assign toggle_conv_go_flag       = strb_q.toggle_go;
  assign dut_sram_write_enable     = strb_q.wr_en;
  assign incr_waddr_enable         = strb_q.incr_waddr;
  assign incr_output_addr          = strb_q.incr_oaddr;
  assign rst_output_row_temp       = strb_q.rst_orow;

endmodule
`default_nettype wire

// File: tb/tb_conv_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_controller
// Purpose  : Directed bench for conv_controller. A small datapath model turns
//            the controller strobes into read/write addresses, row/column
//            flags, dut_busy and conv_go, and the tests compare the resulting
//            counts and state sequences against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_controller;

  localparam logic [3:0] S_IDLE = 4'd0, S_W_DIM = 4'd1, S_W_DAT = 4'd2,
                         S_RD_WAIT = 4'd3, S_I_NROW = 4'd4, S_CONV = 4'd7,
                         S_FLUSH = 4'd8, S_WRITE = 4'd9, S_DONE = 4'd10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dut_run = 1'b0;
  logic [15:0] sram_dut_read_data;
  logic        last_col_next = 1'b0;
  logic        last_row_flag = 1'b0;
  logic        dut_busy_toggle, str_weights_dims, str_weights_data;
  logic        rst_dut_wmem_read_address, str_input_nrows, str_input_ncols;
  logic        incr_raddr_enable, pln_input_row_enable, incr_row_enable;
  logic        rst_row_counter, incr_col_enable, rst_col_counter, update_d_in;
  logic        toggle_conv_go_flag, dut_sram_write_enable, incr_waddr_enable;
  logic        incr_output_addr, rst_output_row_temp;
  logic [3:0]  state;

  conv_controller dut (
    .clk                       (clk),
    .reset                     (reset),
    .dut_run                   (dut_run),
    .sram_dut_read_data        (sram_dut_read_data),
    .last_col_next             (last_col_next),
    .last_row_flag             (last_row_flag),
    .dut_busy_toggle           (dut_busy_toggle),
    .str_weights_dims          (str_weights_dims),
    .str_weights_data          (str_weights_data),
    .rst_dut_wmem_read_address (rst_dut_wmem_read_address),
    .str_input_nrows           (str_input_nrows),
    .str_input_ncols           (str_input_ncols),
    .incr_raddr_enable         (incr_raddr_enable),
    .pln_input_row_enable      (pln_input_row_enable),
    .incr_row_enable           (incr_row_enable),
    .rst_row_counter           (rst_row_counter),
    .incr_col_enable           (incr_col_enable),
    .rst_col_counter           (rst_col_counter),
    .update_d_in               (update_d_in),
    .toggle_conv_go_flag       (toggle_conv_go_flag),
    .dut_sram_write_enable     (dut_sram_write_enable),
    .incr_waddr_enable         (incr_waddr_enable),
    .incr_output_addr          (incr_output_addr),
    .rst_output_row_temp       (rst_output_row_temp),
    .state                     (state)
  );

  always #5 clk = ~clk;

  wire [17:0] all_strobes = {dut_busy_toggle, str_weights_dims, str_weights_data,
    rst_dut_wmem_read_address, str_input_nrows, str_input_ncols, incr_raddr_enable,
    pln_input_row_enable, incr_row_enable, rst_row_counter, incr_col_enable,
    rst_col_counter, update_d_in, toggle_conv_go_flag, dut_sram_write_enable,
    incr_waddr_enable, incr_output_addr, rst_output_row_temp};

  // ---------------- datapath / SRAM model ----------------
  logic [15:0] mem [16];
  int   raddr = 0, waddr = 0;
  int   nrows_cfg = 0, ncols_cfg = 0;
  int   conv_cyc = 0, rows_loaded = 0;
  int   nrows_cnt = 0, ncols_cnt = 0, pln_cnt = 0, raddr_cnt = 0, wr_cnt = 0;
  int   upd_cnt = 0, toggle_cnt = 0, dims_cnt = 0, wdat_cnt = 0;
  int   nrow_entries = 0, conv_entries = 0, wr_snap = -1;
  int   waddr_log [16];
  logic conv_go = 1'b0, go_snap = 1'b1, busy = 1'b0, busy_seen = 1'b0;
  logic both_seen = 1'b0;
  logic [3:0] prev_state = 4'd0;

  always_comb sram_dut_read_data = mem[raddr[3:0]];

  always @(negedge clk) begin
    if (reset) begin
      raddr = 0; waddr = 0; conv_cyc = 0; rows_loaded = 0;
      nrows_cnt = 0; ncols_cnt = 0; pln_cnt = 0; raddr_cnt = 0; wr_cnt = 0;
      upd_cnt = 0; toggle_cnt = 0; dims_cnt = 0; wdat_cnt = 0;
      nrow_entries = 0; conv_entries = 0; wr_snap = -1;
      conv_go = 1'b0; go_snap = 1'b1; busy = 1'b0; busy_seen = 1'b0;
      both_seen = 1'b0; last_col_next = 1'b0; last_row_flag = 1'b0;
      prev_state = state;
    end else begin
      if (str_weights_dims) dims_cnt++;
      if (str_weights_data) wdat_cnt++;
      if (str_input_nrows) begin nrows_cnt++; rows_loaded = 0; end
      if (str_input_ncols) ncols_cnt++;
      if (pln_input_row_enable) begin pln_cnt++; rows_loaded++; end
      if (incr_raddr_enable) begin raddr_cnt++; raddr++; end
      if (!rst_dut_wmem_read_address) raddr = 0;
      if (dut_sram_write_enable) begin
        if (wr_cnt < 16) waddr_log[wr_cnt] = waddr;
        wr_cnt++;
      end
      if (incr_waddr_enable) waddr++;
      if (toggle_conv_go_flag) begin toggle_cnt++; conv_go = ~conv_go; end
      if (dut_busy_toggle) busy = ~busy;
      if (busy) busy_seen = 1'b1;
      if (update_d_in) upd_cnt++;
      if (state == S_I_NROW && prev_state != S_I_NROW) begin
        nrow_entries++;
        if (nrow_entries == 2) begin wr_snap = wr_cnt; go_snap = conv_go; end
      end
      if (state == S_CONV && prev_state != S_CONV) conv_entries++;
      if (state == S_CONV) begin
        last_col_next = (conv_cyc == ncols_cfg - 1);
        conv_cyc++;
      end else begin
        last_col_next = 1'b0;
        conv_cyc = 0;
      end
      last_row_flag = (rows_loaded == nrows_cfg);
      if (state == S_CONV && last_col_next && last_row_flag) both_seen = 1'b1;
      prev_state = state;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0, n_fail = 0;

  task automatic check_value(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [3:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (state !== target && n < budget) begin
      tick();
      n++;
    end
    check_value(tag, int'(state), int'(target));
  endtask

  task automatic do_reset();
    reset = 1'b1; dut_run = 1'b0;
    tick(); tick();
    check_value("reset_state", int'(state), int'(S_IDLE));
    check_value("reset_strobes", int'(all_strobes), 0);
    reset = 1'b0;
    tick();
    check_value("post_reset_rst_col", int'(rst_col_counter), 1);
    check_value("post_reset_rst_row", int'(rst_row_counter), 1);
    check_value("post_reset_rst_raddr", int'(rst_dut_wmem_read_address), 0);
  endtask

  task automatic load_image(input int base, input int nr, input int nc);
    mem[base]     = 16'(nr);
    mem[base + 1] = 16'(nc);
    for (int i = 0; i < nr; i++) mem[base + 2 + i] = 16'hA000 + 16'(i);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 16'h00FF;
  endtask

  task automatic start_run();
    dut_run = 1'b1;
    tick();
    check_value("start_wdim", int'(state), int'(S_W_DIM));
    dut_run = 1'b0;
  endtask

  logic [3:0] seq_exp [8];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- end marker only ----
    clear_mem();
    nrows_cfg = 4; ncols_cfg = 4;
    do_reset();
    start_run();
    wait_state(S_DONE, 20, "marker_reach_done");
    tick();
    check_value("marker_back_idle", int'(state), int'(S_IDLE));
    check_value("marker_busy_seen", int'(busy_seen), 1);
    check_value("marker_busy_low", int'(busy), 0);
    check_value("marker_nrows_pulses", nrows_cnt, 0);
    check_value("marker_writes", wr_cnt, 0);
    check_value("marker_wdims", dims_cnt, 1);
    check_value("marker_wdata", wdat_cnt, 1);

    // ---- dut_run held high: second start only after DONE -> IDLE ----
    do_reset();
    seq_exp = '{S_W_DIM, S_W_DAT, S_W_DAT, S_RD_WAIT, S_I_NROW, S_DONE, S_IDLE, S_W_DIM};
    dut_run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_value($sformatf("held_run_seq%0d", i), int'(state), int'(seq_exp[i]));
    end
    dut_run = 1'b0;
    wait_state(S_DONE, 20, "held_run_done");
    tick();

    // ---- single 4x4 image ----
    clear_mem();
    load_image(0, 4, 4);
    nrows_cfg = 4; ncols_cfg = 4;
    do_reset();
    start_run();
    wait_state(S_DONE, 300, "img4_reach_done");
    tick();
    check_value("img4_writes", wr_cnt, 2);
    check_value("img4_waddr0", waddr_log[0], 0);
    check_value("img4_waddr1", waddr_log[1], 1);
    check_value("img4_conv_cols", upd_cnt, 8);
    check_value("img4_raddr_incr", raddr_cnt, 6);
    check_value("img4_row_loads", pln_cnt, 4);
    check_value("img4_nrows_ncols", nrows_cnt * 10 + ncols_cnt, 11);
    check_value("img4_toggles", toggle_cnt, 4);
    check_value("img4_conv_go_end", int'(conv_go), 0);
    check_value("img4_busy_low", int'(busy), 0);

    // ---- two back-to-back 5x5 images ----
    clear_mem();
    load_image(0, 5, 5);
    load_image(7, 5, 5);
    nrows_cfg = 5; ncols_cfg = 5;
    do_reset();
    start_run();
    wait_state(S_DONE, 600, "img5x2_reach_done");
    tick();
    check_value("img5x2_writes", wr_cnt, 6);
    check_value("img5x2_writes_first", wr_snap, 3);
    check_value("img5x2_go_between", int'(go_snap), 0);
    check_value("img5x2_waddr5", waddr_log[5], 5);
    check_value("img5x2_conv_cols", upd_cnt, 30);
    check_value("img5x2_raddr_incr", raddr_cnt, 14);
    check_value("img5x2_row_loads", pln_cnt, 10);
    check_value("img5x2_toggles", toggle_cnt, 12);
    check_value("img5x2_nrows", nrows_cnt, 2);
    check_value("img5x2_busy_low", int'(busy), 0);

    // ---- reset during CONV of row 2, then clean restart ----
    clear_mem();
    load_image(0, 5, 5);
    do_reset();
    start_run();
    begin
      int n;
      n = 0;
      while (!(state == S_CONV && conv_entries == 2) && n < 300) begin
        tick();
        n++;
      end
    end
    check_value("abort_in_row2_conv", int'(state == S_CONV && conv_entries == 2), 1);
    check_value("abort_writes_before", wr_cnt, 1);
    reset = 1'b1;
    tick();
    check_value("abort_state_idle", int'(state), int'(S_IDLE));
    check_value("abort_strobes_zero", int'(all_strobes), 0);
    reset = 1'b0;
    tick();
    check_value("abort_rst_col", int'(rst_col_counter), 1);
    check_value("abort_no_write", wr_cnt, 0);
    start_run();
    wait_state(S_DONE, 400, "abort_restart_done");
    tick();
    check_value("abort_restart_writes", wr_cnt, 3);
    check_value("abort_restart_waddr2", waddr_log[2], 2);

    // ---- 3x3 image: last_col_next and last_row_flag together ----
    clear_mem();
    load_image(0, 3, 3);
    nrows_cfg = 3; ncols_cfg = 3;
    do_reset();
    start_run();
    wait_state(S_CONV, 100, "both_reach_conv");
    begin
      int n;
      n = 0;
      while (state == S_CONV && n < 50) begin
        tick();
        n++;
      end
    end
    check_value("both_flags_seen", int'(both_seen), 1);
    seq_exp = '{S_FLUSH, S_FLUSH, S_WRITE, S_WRITE, S_RD_WAIT, S_I_NROW, S_DONE, S_IDLE};
    for (int i = 0; i < 8; i++) begin
      check_value($sformatf("both_seq%0d", i), int'(state), int'(seq_exp[i]));
      tick();
    end
    check_value("both_row_loads", pln_cnt, 3);
    check_value("both_writes", wr_cnt, 1);
    check_value("both_toggles", toggle_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
